// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every handshake and memory-bus signal of mem_port_arbiter.
//   Fetch requester : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   Data requester  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   Memory port     : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   Status          : busy
// Modports:
//   slave  - the arbiter itself
//   master - the environment (both requesters plus the memory)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// requester (read-only) and the data requester (loads/stores). One transaction
// is outstanding at a time. Read data is returned with a one-cycle rvalid
// pulse to whichever requester issued the access.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mem_port_arbiter_if.slave (requester handshakes, memory port, busy)
// Parameters:
//   MEM_LAT      - cycles from mem_en to valid mem_rdata (>= 1)
//   MAX_DATA_RUN - contested data grants in a row before fetch is forced in (>= 1)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);

    localparam int RUN_W  = $clog2(MAX_DATA_RUN + 1);
    // A one-cycle latency never enters WAIT, but the counter still needs a bit.
    localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_DATA_RUN);
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPT
    } state_e;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               owner_data_q, owner_data_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;

    logic               if_gnt;
    logic               d_gnt;
    logic               force_if;

    // Grant selection. Grants exist only in IDLE and are masked during reset
    // so nothing is accepted while the block is being cleared. Data normally
    // wins a contest; once the run counter saturates fetch gets its turn.
    always_comb begin
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        force_if = (run_q == RUN_MAX);
        if ((state_q == ST_IDLE) && !rst) begin
            if (bus.d_req && !(bus.if_req && force_if)) begin
                d_gnt = 1'b1;
            end else if (bus.if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Next-state logic. mem_we_q is only high during ISSUE of a store, so it
    // doubles as the "this transaction is a store" flag at the ISSUE decision.
    // The WAIT counter is loaded with MEM_LAT-1 and leaves WAIT as it reaches
    // zero, giving MEM_LAT-1 WAIT cycles between ISSUE and CAPT.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (if_gnt || d_gnt) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_we_q) begin
                    state_d = ST_IDLE;
                end else if (MEM_LAT > 1) begin
                    state_d = ST_WAIT;
                    wcnt_d  = WAIT_INIT;
                end else begin
                    state_d = ST_CAPT;
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - WCNT_W'(1);
                if (wcnt_q == WCNT_W'(1)) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output logic: latch the granted request into the memory
    // output registers, track the data-run counter, and route captured read
    // data to the owner of the transaction.
    always_comb begin
        run_d        = run_q;
        owner_data_d = owner_data_q;
        mem_en_d     = if_gnt || d_gnt;
        mem_we_d     = d_gnt && bus.d_we;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (d_gnt) begin
            owner_data_d = 1'b1;
            mem_addr_d   = bus.d_addr;
            mem_wdata_d  = bus.d_wdata;
            // Only contested data grants extend the run.
            if (bus.if_req) begin
                run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            end else begin
                run_d = '0;
            end
        end else if (if_gnt) begin
            owner_data_d = 1'b0;
            mem_addr_d   = bus.if_addr;
            run_d        = '0;
        end

        if_rvalid_d = (state_q == ST_CAPT) && !owner_data_q;
        d_rvalid_d  = (state_q == ST_CAPT) && owner_data_q;
        if_rdata_d  = if_rvalid_d ? bus.mem_rdata : if_rdata_q;
        d_rdata_d   = d_rvalid_d  ? bus.mem_rdata : d_rdata_q;
    end

    // State register. Reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            run_q        <= '0;
            wcnt_q       <= '0;
            owner_data_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            wcnt_q       <= wcnt_d;
            owner_data_q <= owner_data_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
